ct_addsub_stream: RTL and testbench

Parametrised, sequential successor to the combinational ciphertext adder. Accepts one full ciphertext pair (plus optional plaintext) over a valid/ready handshake. It applies a selectable modular operation slot-by-slot, processing LANES slots per cycle, and returns the result ciphertext over a second valid/ready handshake. It sits between the ciphertext register file and the downstream multiply/relinearise path.

---
 rtl/ct_addsub_stream_pkg.sv | 33 +++
 rtl/ct_addsub_stream_lane_alu.sv | 45 ++++
 rtl/ct_addsub_stream.sv | 143 ++++++++++++++
 tb/tb_ct_addsub_stream.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_addsub_stream_pkg.sv
// Shared types and constants for the streaming ciphertext add/sub block.
package ct_addsub_stream_pkg;

  localparam int N_SLOTS_L = 8;     // slots per polynomial vector
  localparam int W_BITS    = 16;    // coefficient width
  localparam int Q_MOD     = 7710;  // ciphertext modulus
  localparam int T_MOD     = 257;   // plaintext modulus
  localparam int DELTA     = 30;    // plaintext scale
  localparam int LANES     = 2;     // slots processed per cycle
  localparam int N_STEPS   = N_SLOTS_L / LANES;

  typedef logic [W_BITS-1:0]   coef_t;
  typedef coef_t [N_SLOTS_L-1:0] vec_t;

  typedef struct packed {
    vec_t a;
    vec_t b;
  } CT_t;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_PTADD = 2'b10,
    OP_NEG   = 2'b11
  } ct_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ct_addsub_stream_lane_alu.sv
// One reduced modular coefficient operation. IS_B selects whether this
// instance sits on the B vector, which is the only one that adds the
// scaled plaintext; on the A vector the plaintext op is a pass-through.
module ct_lane_alu
  import ct_addsub_stream_pkg::*;
#(
  parameter bit IS_B = 1'b0
) (
  input  coef_t  a_i,
  input  coef_t  b_i,
  input  coef_t  pt_i,
  input  ct_op_e op_i,
  output coef_t  res_o
);

  localparam logic [W_BITS:0]     Q_EXT     = (W_BITS+1)'(Q_MOD);
  localparam coef_t               Q_W       = W_BITS'(Q_MOD);
  localparam logic [2*W_BITS-1:0] DELTA_EXT = (2*W_BITS)'(DELTA);

  coef_t           pt_scaled;
  coef_t           addend;
  logic [W_BITS:0] sum;
  coef_t           sum_mod;
  coef_t           diff;

  // DELTA*pt never reaches Q, so the low word of the wide product is exact.
  assign pt_scaled = W_BITS'(DELTA_EXT * {{W_BITS{1'b0}}, pt_i});

  // Modular add/sub/negate with a single conditional correction each.
  always_comb begin
    addend  = (op_i == OP_PTADD) ? pt_scaled : b_i;
    sum     = {1'b0, a_i} + {1'b0, addend};
    sum_mod = (sum >= Q_EXT) ? W_BITS'(sum - Q_EXT) : sum[W_BITS-1:0];
    diff    = a_i - b_i;
    res_o   = a_i;
    case (op_i)
      OP_ADD:   res_o = sum_mod;
      OP_SUB:   res_o = (a_i < b_i) ? (diff + Q_W) : diff;
      OP_PTADD: res_o = IS_B ? sum_mod : a_i;
      OP_NEG:   res_o = (a_i == '0) ? '0 : (Q_W - a_i);
      default:  res_o = a_i;
    endcase
  end

endmodule

// File: rtl/ct_addsub_stream.sv
// Streaming ciphertext add/sub/plaintext-add/negate, LANES slots per cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and data stable until that edge;
// out_valid, once raised, stays high with out_ct stable until out_ready.
module ct_addsub_stream
  import ct_addsub_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_mode,
  input  CT_t        in_ct1,
  input  CT_t        in_ct2,
  input  vec_t       in_pt,
  output logic       out_valid,
  input  logic       out_ready,
  output CT_t        out_ct,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = $clog2(N_STEPS + 1);
  localparam int IW    = $clog2(N_SLOTS_L);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(N_STEPS);

  if (N_SLOTS_L % LANES != 0) begin : g_chk_lanes
    $error("N_SLOTS must be a multiple of LANES");
  end
  if (longint'(Q_MOD) >= (longint'(1) << W_BITS)) begin : g_chk_q
    $error("Q_MOD must be below 2^W_BITS");
  end
  if (DELTA * (T_MOD - 1) >= Q_MOD) begin : g_chk_delta
    $error("DELTA*(T_MOD-1) must be below Q_MOD");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] slice;
  ct_op_e           op_q;
  CT_t              ct1_q, ct2_q;
  vec_t             pt_q;
  CT_t              out_ct_q, out_ct_d;
  logic             accept;

  logic [IW-1:0] slot_idx [LANES];
  coef_t a1 [LANES], a2 [LANES], b1 [LANES], b2 [LANES], pt [LANES];
  coef_t res_a [LANES], res_b [LANES];

  // FSM next state; a capture in DONE coincides with the pop of the result.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // cnt runs one past the last slice: that settle cycle lets the final
        // slice land in out_ct before out_valid is raised.
        if (cnt_q == CNT_END) state_d = ST_DONE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the slots handled this cycle and route operands to the lanes.
  always_comb begin
    slice = (cnt_q < CNT_END) ? cnt_q : '0;
    for (int l = 0; l < LANES; l++) begin
      slot_idx[l] = IW'(int'(slice) * LANES + l);
      a1[l] = ct1_q.a[slot_idx[l]];
      a2[l] = ct2_q.a[slot_idx[l]];
      b1[l] = ct1_q.b[slot_idx[l]];
      b2[l] = ct2_q.b[slot_idx[l]];
      pt[l] = pt_q[slot_idx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ct_lane_alu #(.IS_B(1'b0)) u_alu_a (
      .a_i(a1[l]), .b_i(a2[l]), .pt_i(pt[l]), .op_i(op_q), .res_o(res_a[l])
    );
    ct_lane_alu #(.IS_B(1'b1)) u_alu_b (
      .a_i(b1[l]), .b_i(b2[l]), .pt_i(pt[l]), .op_i(op_q), .res_o(res_b[l])
    );
  end

  // Merge this cycle's lane results into the result register.
  always_comb begin
    out_ct_d = out_ct_q;
    if ((state_q == ST_RUN) && (cnt_q != CNT_END)) begin
      for (int l = 0; l < LANES; l++) begin
        out_ct_d.a[slot_idx[l]] = res_a[l];
        out_ct_d.b[slot_idx[l]] = res_b[l];
      end
    end
  end

  // State, counter, operand capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      ct1_q    <= '0;
      ct2_q    <= '0;
      pt_q     <= '0;
      out_ct_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_ct_q <= out_ct_d;
      if (accept) begin
        op_q  <= ct_op_e'(in_mode);
        ct1_q <= in_ct1;
        ct2_q <= in_ct2;
        pt_q  <= in_pt;
      end
    end
  end

  assign out_ct    = out_ct_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ct_addsub_stream.sv
// Bench for ct_addsub_stream: directed cases, back-pressure, mid-run reset
// and a randomized run, checked against an arithmetic reference model.
module tb_ct_addsub_stream;
  import ct_addsub_stream_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  CT_t        in_ct1, in_ct2;
  vec_t       in_pt;
  logic       out_valid;
  logic       out_ready;
  CT_t        out_ct;
  logic       busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ct_addsub_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_ct1(in_ct1), .in_ct2(in_ct2), .in_pt(in_pt),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  CT_t exp_q[$];
  time acc_q[$];
  int  n_vec  = 0;
  int  n_fail = 0;
  CT_t last_out;
  bit  prev_valid = 1'b0;
  bit  rand_done  = 1'b0;

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ct(input string name, input CT_t act, input CT_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // ---------------- reference model ----------------
  function automatic CT_t model(input logic [1:0] mode, input CT_t c1,
                                input CT_t c2, input vec_t pt);
    CT_t r;
    int  a1, a2, b1, b2, p;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      a1 = int'(c1.a[i]); a2 = int'(c2.a[i]);
      b1 = int'(c1.b[i]); b2 = int'(c2.b[i]);
      p  = int'(pt[i]);
      case (mode)
        2'b00: begin
          r.a[i] = coef_t'((a1 + a2) % Q_MOD);
          r.b[i] = coef_t'((b1 + b2) % Q_MOD);
        end
        2'b01: begin
          r.a[i] = coef_t'((a1 - a2 + Q_MOD) % Q_MOD);
          r.b[i] = coef_t'((b1 - b2 + Q_MOD) % Q_MOD);
        end
        2'b10: begin
          r.a[i] = coef_t'(a1);
          r.b[i] = coef_t'((b1 + DELTA * p) % Q_MOD);
        end
        default: begin
          r.a[i] = coef_t'((Q_MOD - a1) % Q_MOD);
          r.b[i] = coef_t'((Q_MOD - b1) % Q_MOD);
        end
      endcase
    end
    return r;
  endfunction

  function automatic vec_t rand_vec(input int hi);
    vec_t v;
    for (int i = 0; i < N_SLOTS_L; i++) v[i] = coef_t'($urandom_range(0, hi));
    return v;
  endfunction

  function automatic CT_t rand_ct();
    CT_t c;
    c.a = rand_vec(Q_MOD - 1);
    c.b = rand_vec(Q_MOD - 1);
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one operation and waits (bounded) for the accepting edge.
  // Inputs are scrambled afterwards so late sampling would be caught.
  task automatic drive_op(input logic [1:0] mode, input CT_t c1,
                          input CT_t c2, input vec_t pt);
    bit acc = 1'b0;
    bit rdy;
    in_mode = mode; in_ct1 = c1; in_ct2 = c2; in_pt = pt; in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        exp_q.push_back(model(mode, c1, c2, pt));
        acc_q.push_back($time);
      end
    end
    #1;
    in_valid = 1'b0;
    in_mode  = 2'($urandom_range(0, 3));
    in_ct1   = rand_ct();
    in_ct2   = rand_ct();
    in_pt    = rand_vec(T_MOD - 1);
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail_now("spurious_valid");
        else chk_int("latency", int'(($time - acc_q.pop_front() - 5) / 10), N_STEPS + 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else begin
          chk_ct("result", out_ct, exp_q.pop_front());
          last_out = out_ct;
        end
      end
    end
    prev_valid = out_valid && rst_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    CT_t  c1, c2;
    vec_t pt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 2'b00; in_ct1 = '0; in_ct2 = '0; in_pt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_in_ready", int'(in_ready), 0);
    chk_int("rst_state", int'(dbg_state), 0);
    chk_ct("rst_out_ct", out_ct, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed vectors shared by the add/sub/pt/neg cases.
    c1 = rand_ct(); c2 = rand_ct(); pt = rand_vec(T_MOD - 1);
    c1.a[0] = 16'd1429; c2.a[0] = 16'd1081;
    c1.b[0] = 16'd7531; c2.b[0] = 16'd1577;
    c1.a[3] = 16'd3279; c2.a[3] = 16'd5762;

    drive_op(2'b00, c1, c2, pt); wait_idle();
    chk_int("add_a0", int'(last_out.a[0]), 2510);
    chk_int("add_b0_wrap", int'(last_out.b[0]), 1398);

    drive_op(2'b01, c1, c2, pt); wait_idle();
    chk_int("sub_a0", int'(last_out.a[0]), 348);
    chk_int("sub_a3_borrow", int'(last_out.a[3]), 5227);
    chk_int("sub_b0", int'(last_out.b[0]), 5954);

    pt[0] = 16'd5;
    drive_op(2'b10, c1, c2, pt); wait_idle();
    chk_int("pt5_b0", int'(last_out.b[0]), 7681);
    chk_int("pt_a0_pass", int'(last_out.a[0]), 1429);
    pt[0] = 16'd10;
    drive_op(2'b10, c1, c2, pt); wait_idle();
    chk_int("pt10_b0_wrap", int'(last_out.b[0]), 121);

    c1.a[1] = 16'd0; c1.a[2] = 16'd7709;
    drive_op(2'b11, c1, c2, pt); wait_idle();
    chk_int("neg_a0", int'(last_out.a[0]), 6281);
    chk_int("neg_zero", int'(last_out.a[1]), 0);
    chk_int("neg_qm1", int'(last_out.a[2]), 1);

    // Back-pressure in DONE, then pop and new accept on the same edge.
    out_ready = 1'b0;
    drive_op(2'b00, rand_ct(), rand_ct(), rand_vec(T_MOD - 1));
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    if (!out_valid) fail_now("stall_valid_timeout");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) chk_ct("stall_out_ct", out_ct, exp_q[0]);
      chk_int("stall_in_ready", int'(in_ready), 0);
      chk_int("stall_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drive_op(2'b01, rand_ct(), rand_ct(), rand_vec(T_MOD - 1));
    @(negedge clk);
    chk_int("b2b_state_run", int'(dbg_state), 1);
    chk_int("b2b_valid_low", int'(out_valid), 0);
    wait_idle();

    // Reset during the second RUN cycle discards the operation.
    drive_op(2'b00, rand_ct(), rand_ct(), rand_vec(T_MOD - 1));
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete(); acc_q.delete();
    @(posedge clk); @(negedge clk);
    chk_int("abort_out_valid", int'(out_valid), 0);
    chk_int("abort_busy", int'(busy), 0);
    chk_int("abort_state", int'(dbg_state), 0);
    chk_int("abort_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive_op(2'b10, rand_ct(), rand_ct(), rand_vec(T_MOD - 1));
    wait_idle();

    // Randomized traffic with random consumer stalls.
    fork
      begin
        int gap;
        for (int k = 0; k < 40; k++) begin
          drive_op(2'($urandom_range(0, 3)), rand_ct(), rand_ct(), rand_vec(T_MOD - 1));
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    chk_int("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
